// File: rtl/mem_pkg.sv
// Shared widths, register-bank aliases, FSM encoding and request format
// for the memory access controller.
package mem_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] REG_A = 6'd63;
    localparam logic [ADDR_W-1:0] REG_B = 6'd62;
    localparam logic [ADDR_W-1:0] REG_C = 6'd61;
    localparam logic [ADDR_W-1:0] REG_D = 6'd60;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_ctrl_req_fifo.sv
// Small request queue: DEPTH entries of {we, addr, wdata}, synchronous
// push/pop, head visible combinationally for the controller to latch.
module req_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  req_t push_data,
    input  logic pop,
    output req_t head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    req_t             entry_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Flags come straight from the registered count so req_ready has no
    // combinational path from the pop side.
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entry_q[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            req_t entry_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    entry_reg <= '0;
                end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Load/store sequencer in front of the 64x16 RAM: queues core requests,
// drives the RAM pins for one cycle per access and holds load responses.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              wr_done,
    output logic              busy,
    output logic              ram_write,
    output logic              ram_read,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            state_reg;
    logic              cmd_we_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_wdata_reg;
    logic              ram_write_reg;
    logic              ram_read_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              wr_done_reg;

    req_t push_req;
    req_t head_req;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;

    assign push_req = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign fifo_pop = (state_reg == IDLE) && !fifo_empty;

    req_fifo #(
        .DEPTH(DEPTH)
    ) u_req_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (req_valid),
        .push_data(push_req),
        .pop      (fifo_pop),
        .head     (head_req),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // RAM strobes are set on the pop edge so they are high for exactly the
    // ACCESS cycle; addr/wdata are left holding afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cmd_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            ram_write_reg <= 1'b0;
            ram_read_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            wr_done_reg   <= 1'b0;
        end else begin
            wr_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        cmd_we_reg    <= head_req.we;
                        ram_addr_reg  <= head_req.addr;
                        ram_wdata_reg <= head_req.wdata;
                        ram_write_reg <= head_req.we;
                        ram_read_reg  <= !head_req.we;
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_write_reg <= 1'b0;
                    ram_read_reg  <= 1'b0;
                    if (cmd_we_reg) begin
                        wr_done_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        rsp_data_reg  <= ram_rdata;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_reg != IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign wr_done   = wr_done_reg;
    assign ram_write = ram_write_reg;
    assign ram_read  = ram_read_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;

endmodule
